// File: rtl/ram_1w_1rs_ext.sv
// Single-write / single-read RAM with write lane masks, 1- or 2-cycle registered read,
// configurable read-under-write behaviour and an optional post-reset clear sweep.
module ram_1w_1rs_ext #(
  parameter int                   wordCount      = 32,
  parameter int                   wordWidth      = 32,
  parameter int                   addressWidth   = 5,
  parameter int                   wrMaskWidth    = 4,
  parameter int                   wrMaskEnable   = 1,
  parameter string                readUnderWrite = "readFirst",
  parameter int                   readLatency    = 1,
  parameter int                   initOnReset    = 1,
  parameter logic [wordWidth-1:0] initValue      = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [wrMaskWidth-1:0]  wr_mask,
  input  logic [addressWidth-1:0] wr_addr,
  input  logic [wordWidth-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [addressWidth-1:0] rd_addr,
  output logic [wordWidth-1:0]    rd_data,
  output logic                    rd_valid
);

  localparam int LANE_W = (wrMaskWidth > 0) ? wordWidth / wrMaskWidth : 1;
  localparam bit WRITE_FIRST = (readUnderWrite == "writeFirst");
  localparam logic [addressWidth:0]   DEPTH     = (addressWidth + 1)'(wordCount);
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(wordCount - 1);

  if (wordCount < 2) begin : g_bad_word_count
    $error("ram_1w_1rs_ext: wordCount must be >= 2");
  end
  if (addressWidth < 1 || (addressWidth < 31 && (1 << addressWidth) < wordCount)) begin : g_bad_addr_width
    $error("ram_1w_1rs_ext: addressWidth too small for wordCount");
  end
  if (wrMaskWidth < 1 || (wordWidth % wrMaskWidth) != 0) begin : g_bad_mask_width
    $error("ram_1w_1rs_ext: wordWidth must be divisible by wrMaskWidth");
  end
  if (wrMaskEnable != 0 && wrMaskEnable != 1) begin : g_bad_mask_enable
    $error("ram_1w_1rs_ext: wrMaskEnable must be 0 or 1");
  end
  if (readUnderWrite != "readFirst" && readUnderWrite != "writeFirst" &&
      readUnderWrite != "dontCare") begin : g_bad_ruw
    $error("ram_1w_1rs_ext: readUnderWrite must be readFirst, writeFirst or dontCare");
  end
  if (readLatency != 1 && readLatency != 2) begin : g_bad_latency
    $error("ram_1w_1rs_ext: readLatency must be 1 or 2");
  end
  if (initOnReset != 0 && initOnReset != 1) begin : g_bad_init
    $error("ram_1w_1rs_ext: initOnReset must be 0 or 1");
  end

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [addressWidth-1:0] clr_cnt_q, clr_cnt_d;

  logic [wordWidth-1:0] mem [wordCount];

  logic                    wr_fire, rd_fire, wr_in_range, rd_in_range;
  logic [wrMaskWidth-1:0]  wr_lanes, mem_lanes;
  logic [wordWidth-1:0]    wr_bits, mem_wdata, rd_word;
  logic [addressWidth-1:0] mem_waddr;
  logic                    mem_we;

  logic                 s1_valid_q, s1_valid_d;
  logic [wordWidth-1:0] s1_data_q, s1_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [wordWidth-1:0] rd_data_q, rd_data_d;

  assign init_busy   = (state_q == CLEAR);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
  assign wr_fire     = wr_en && !init_busy && wr_in_range;
  assign rd_fire     = rd_en && !init_busy;
  assign wr_lanes    = (wrMaskEnable != 0) ? wr_mask : '1;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // The clear sweep owns the write port; user requests are dropped meanwhile.
  always_comb begin
    mem_we    = wr_fire;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_lanes = wr_lanes;
    if (init_busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = initValue;
      mem_lanes = '1;
    end
  end

  always_comb begin
    wr_bits = '0;
    for (int i = 0; i < wrMaskWidth; i++) begin
      wr_bits[i*LANE_W +: LANE_W] = {LANE_W{wr_lanes[i]}};
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (WRITE_FIRST && wr_fire && (wr_addr == rd_addr)) begin
        rd_word = (rd_word & ~wr_bits) | (wr_data & wr_bits);
      end
    end
  end

  // Stage 1 captures the word at accept time, so later writes cannot disturb it.
  always_comb begin
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
    if (readLatency == 2) begin
      rd_valid_d = s1_valid_q;
      rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
    end else begin
      rd_valid_d = rd_fire;
      rd_data_d  = rd_fire ? rd_word : rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (initOnReset != 0) ? CLEAR : IDLE;
      clr_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: the array has no reset; its contents come only from writes or the clear sweep.
  always_ff @(posedge clk) begin
    for (int i = 0; i < wrMaskWidth; i++) begin
      if (mem_we && mem_lanes[i]) begin
        mem[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_1w_1rs_ext.sv
// Directed bench for ram_1w_1rs_ext: four configurations, read results checked against
// a scoreboard of expected word and arrival cycle.
module tb_ram_1w_1rs_ext;

  localparam int NI = 4;  // 0: defaults, 1: writeFirst/latency 2, 2: depth 20, 3: no clear
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset     [NI];
  logic          init_busy [NI];
  logic          wr_en     [NI];
  logic [MW-1:0] wr_mask   [NI];
  logic [AW-1:0] wr_addr   [NI];
  logic [DW-1:0] wr_data   [NI];
  logic          rd_en     [NI];
  logic [AW-1:0] rd_addr   [NI];
  logic [DW-1:0] rd_data   [NI];
  logic          rd_valid  [NI];

  ram_1w_1rs_ext u_def (
    .clk(clk), .reset(reset[0]), .init_busy(init_busy[0]),
    .wr_en(wr_en[0]), .wr_mask(wr_mask[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0])
  );

  ram_1w_1rs_ext #(.readUnderWrite("writeFirst"), .readLatency(2)) u_wf2 (
    .clk(clk), .reset(reset[1]), .init_busy(init_busy[1]),
    .wr_en(wr_en[1]), .wr_mask(wr_mask[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1])
  );

  ram_1w_1rs_ext #(.wordCount(20)) u_np2 (
    .clk(clk), .reset(reset[2]), .init_busy(init_busy[2]),
    .wr_en(wr_en[2]), .wr_mask(wr_mask[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2])
  );

  ram_1w_1rs_ext #(.initOnReset(0)) u_noclr (
    .clk(clk), .reset(reset[3]), .init_busy(init_busy[3]),
    .wr_en(wr_en[3]), .wr_mask(wr_mask[3]), .wr_addr(wr_addr[3]), .wr_data(wr_data[3]),
    .rd_en(rd_en[3]), .rd_addr(rd_addr[3]), .rd_data(rd_data[3]), .rd_valid(rd_valid[3])
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            inst;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   busy_cnt [NI];

  function automatic int lat_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      rd_en[g] = 1'b0;
      wr_en[g] = 1'b0;
    end
  endtask

  task automatic wr(input int g, input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    wr_en[g]   = 1'b1;
    wr_addr[g] = AW'(a);
    wr_data[g] = d;
    wr_mask[g] = m;
  endtask

  task automatic rd(input int g, input int a, input logic [DW-1:0] e);
    exp_t item;
    rd_en[g]   = 1'b1;
    rd_addr[g] = AW'(a);
    item.inst  = g;
    item.data  = e;
    item.due   = cyc + lat_of(g);
    sb.push_back(item);
  endtask

  // Holds read and write requests on every busy instance; they must all be dropped.
  task automatic measure_busy();
    bit any;
    for (int g = 0; g < NI; g++) busy_cnt[g] = 0;
    for (int c = 0; c < 100; c++) begin
      any = 1'b0;
      for (int g = 0; g < NI; g++) begin
        if (init_busy[g] === 1'b1) begin
          busy_cnt[g]++;
          any        = 1'b1;
          rd_en[g]   = 1'b1;
          rd_addr[g] = AW'(c);
          wr(g, 9, 32'hDEAD_BEEF, 4'hF);
        end
      end
      if (!any) break;
      tick();
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      int idx;
      idx = -1;
      for (int k = 0; k < sb.size(); k++) begin
        if (idx < 0 && sb[k].inst == g && sb[k].due == cyc) idx = k;
      end
      if (idx >= 0) begin
        check($sformatf("rd_valid%0d@%0d", g, cyc), DW'(rd_valid[g]), 32'd1);
        check($sformatf("rd_data%0d@%0d", g, cyc), rd_data[g], sb[idx].data);
        sb.delete(idx);
      end else begin
        check($sformatf("idle_rd_valid%0d@%0d", g, cyc), DW'(rd_valid[g]), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      reset[g]   = 1'b1;
      wr_en[g]   = 1'b0;
      rd_en[g]   = 1'b0;
      wr_mask[g] = '0;
      wr_addr[g] = '0;
      wr_data[g] = '0;
      rd_addr[g] = '0;
    end
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_rd_data%0d", g), rd_data[g], 32'd0);
      check($sformatf("rst_init_busy%0d", g), DW'(init_busy[g]), (g == 3) ? 32'd0 : 32'd1);
    end

    // Clear sweep length per configuration, with requests held throughout.
    for (int g = 0; g < NI; g++) reset[g] = 1'b0;
    measure_busy();
    check("busy_len_def", busy_cnt[0], 32'd32);
    check("busy_len_wf2", busy_cnt[1], 32'd32);
    check("busy_len_np2", busy_cnt[2], 32'd20);
    check("busy_len_noclr", busy_cnt[3], 32'd0);

    // Every location reads back the clear value; latency-2 reads issued back to back.
    for (int a = 0; a < 32; a++) begin
      rd(0, a, 32'd0);
      rd(1, a, 32'd0);
      if (a < 20) rd(2, a, 32'd0);
      tick();
    end
    tick();
    tick();

    // Lane-masked write.
    wr(0, 3, 32'hAABB_CCDD, 4'hF); tick();
    wr(0, 3, 32'h1122_3344, 4'b0101); tick();
    rd(0, 3, 32'hAA22_CC44); tick();
    tick();
    check("rd_hold", rd_data[0], 32'hAA22_CC44);

    // readFirst collision returns the old word, the next read the new one.
    wr(0, 5, 32'h1, 4'hF); tick();
    wr(0, 5, 32'h2, 4'hF); rd(0, 5, 32'h1); tick();
    rd(0, 5, 32'h2); tick();
    tick();

    // writeFirst collision with latency 2, then a write right behind the read.
    wr(1, 7, 32'hFFFF_0000, 4'hF); tick();
    wr(1, 7, 32'h0000_1234, 4'b0011); rd(1, 7, 32'hFFFF_1234); tick();
    wr(1, 7, 32'hABCD_ABCD, 4'hF); tick();
    rd(1, 7, 32'hABCD_ABCD); tick();
    tick();
    tick();

    // Depth 20: out-of-range write ignored, out-of-range read returns 0.
    wr(2, 25, 32'h0000_0055, 4'hF); tick();
    wr(2, 19, 32'h0000_0077, 4'hF); tick();
    rd(2, 25, 32'd0); tick();
    rd(2, 5, 32'd0); tick();
    rd(2, 9, 32'd0); tick();
    rd(2, 19, 32'h0000_0077); tick();
    tick();

    // No clear sweep: contents survive reset, busy stays low.
    wr(3, 4, 32'h1234_5678, 4'hF); tick();
    rd(3, 4, 32'h1234_5678); tick();
    reset[3] = 1'b1;
    tick();
    tick();
    check("noclr_busy_in_reset", DW'(init_busy[3]), 32'd0);
    check("noclr_rd_data_reset", rd_data[3], 32'd0);
    reset[3] = 1'b0;
    rd(3, 4, 32'h1234_5678); tick();
    tick();

    // A read in flight when reset hits produces no rd_valid (no scoreboard entry).
    rd_en[1]   = 1'b1;
    rd_addr[1] = AW'(7);
    tick();
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    check("inflight_rd_data_reset", rd_data[1], 32'd0);
    check("inflight_busy_after_reset", DW'(init_busy[1]), 32'd1);
    measure_busy();
    check("busy_len_wf2_again", busy_cnt[1], 32'd32);
    tick();
    tick();

    // Reset at cycle 10 of the sweep restarts it from address 0.
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rd_en[0]   = 1'b1;
      rd_addr[0] = AW'(c);
      tick();
    end
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    check("midclear_busy", DW'(init_busy[0]), 32'd1);
    measure_busy();
    check("busy_len_restart", busy_cnt[0], 32'd32);
    rd(0, 3, 32'd0); tick();
    rd(0, 5, 32'd0); tick();
    tick();
    tick();
    tick();

    check("scoreboard_drained", DW'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_1w_1rs_ext.md
RAM_1W_1RS_EXT -- requirements
Module: ram_1w_1rs_ext

Interface
REQ-001 SHALL have parameter wordCount, default 32, meaning number of words; any value >= 2, not required to be a power of two.
REQ-002 SHALL have parameter wordWidth, default 32, meaning bits per word.
REQ-003 SHALL have parameter addressWidth, default 5, meaning address bits; must satisfy 2**addressWidth >= wordCount.
REQ-004 SHALL have parameter wrMaskWidth, default 4, meaning write lanes; wordWidth must be divisible by wrMaskWidth.
REQ-005 SHALL have parameter wrMaskEnable, default 1, meaning 0 treats every write as full-word.
REQ-006 SHALL have parameter readUnderWrite, default "readFirst", meaning same-cycle same-address collision mode: "readFirst", "writeFirst" or "dontCare".
REQ-007 SHALL have parameter readLatency, default 1, meaning cycles from read request to data; legal values 1 or 2.
REQ-008 SHALL have parameter initOnReset, default 1, meaning 1 enables clearing of the whole array after reset.
REQ-009 SHALL have parameter initValue, default 0, meaning the word written to every location by the clear sequence.
REQ-010 SHALL flag an elaboration error on any illegal parameter value or combination.
REQ-011 clk  input  1  single clock; all logic on the rising edge.
REQ-012 reset  input  1  synchronous, active-high reset.
REQ-013 init_busy  output  1  high while the clear sequence runs.
REQ-014 wr_en  input  1  write request.
REQ-015 wr_mask  input  wrMaskWidth  lane enables, bit i covers bits [i*W +: W], W = wordWidth/wrMaskWidth.
REQ-016 wr_addr  input  addressWidth  write address.
REQ-017 wr_data  input  wordWidth  write data.
REQ-018 rd_en  input  1  read request.
REQ-019 rd_addr  input  addressWidth  read address.
REQ-020 rd_data  output  wordWidth  registered read data.
REQ-021 rd_valid  output  1  one-cycle pulse aligned with new rd_data.

Function
REQ-022 A write SHALL be accepted when wr_en=1 and init_busy=0, and SHALL update only the lanes whose mask bit is 1 (all lanes if wrMaskEnable=0) at the next edge.
REQ-023 A read SHALL be accepted when rd_en=1 and init_busy=0; data and rd_valid=1 SHALL appear exactly readLatency cycles later.
REQ-024 With readLatency=2, an accepted read SHALL pass through two register stages; back-to-back reads SHALL be accepted every cycle, with full throughput.
REQ-025 rd_data SHALL hold its last value when no read completes; rd_valid=0 on those cycles.
REQ-026 Same-cycle write and read to the same in-range address, readFirst: rd_data SHALL return the pre-write word.
REQ-027 Same-cycle collision, writeFirst: rd_data SHALL return the merged word, with masked lanes from wr_data and the other lanes from the old word.
REQ-028 Same-cycle collision, dontCare: rd_data content is unspecified, but rd_valid timing SHALL still follow REQ-023.
REQ-029 A write in the cycle after an accepted read (readLatency=2) SHALL NOT alter that read's returned data.
REQ-030 Writes to addresses >= wordCount SHALL be ignored; reads from addresses >= wordCount SHALL return 0 with normal rd_valid timing.
REQ-031 The init FSM SHALL have states IDLE and CLEAR, and SHALL use a clear counter of addressWidth bits.
REQ-032 On reset with initOnReset=1, the FSM SHALL enter CLEAR with counter=0 and init_busy=1 on the first cycle after reset deasserts.
REQ-033 In CLEAR, the FSM SHALL write initValue (full word) to address counter each cycle and increment the counter.
REQ-034 After writing address wordCount-1, the FSM SHALL go to IDLE and drop init_busy, so that init_busy is high for exactly wordCount cycles.
REQ-035 With initOnReset=0, the FSM SHALL stay in IDLE, init_busy SHALL be constantly 0, and memory contents SHALL be preserved across reset.
REQ-036 Requests presented while init_busy=1 SHALL be dropped, not queued.
REQ-037 Reads already in flight when reset asserts SHALL be discarded, and no rd_valid SHALL be produced for them.

Reset
REQ-038 During and after reset, rd_valid=0, rd_data=0 and all pipeline valid bits=0.
REQ-039 During and after reset, init_busy SHALL be 1 if initOnReset=1 and 0 otherwise.
REQ-040 Reset asserted mid-CLEAR SHALL restart the clear sequence at address 0.
REQ-041 Memory contents are not otherwise reset.

Verification
REQ-042 Clear sequence: defaults, reset 1 cycle -> init_busy high exactly 32 cycles; a read of every address afterwards returns 0.
REQ-043 Masked write: write 0xAABBCCDD to addr 3, then wr_mask=0b0101 with data 0x11223344 -> read addr 3 returns 0xAA22CC44 one cycle after rd_en.
REQ-044 readFirst collision: addr 5 holds 0x1; same cycle, write 0x2 and read addr 5 -> rd_data=0x1; a following read returns 0x2.
REQ-045 writeFirst collision, readLatency=2: addr 7 holds 0xFFFF0000; same cycle, write 0x00001234 with mask 0b0011 and read addr 7 -> rd_data=0xFFFF1234 two cycles later with rd_valid pulse.
REQ-046 Non-power-of-two depth: wordCount=20 -> init_busy lasts 20 cycles; a write to addr 25 is ignored; a read of addr 25 returns 0.
REQ-047 Busy/reset: rd_en held during CLEAR gives no rd_valid; reset asserted at cycle 10 of CLEAR restarts the sequence with a full 32-cycle busy.
